// File: rtl/uart_responder_pkg.sv
// Shared definitions for the UART bus responder.
// Holds register offsets, STATUS bit positions, the serial FSM state
// encoding shared by the TX and RX engines, the minimum bit period and a
// helper that clamps a requested bit period to that minimum.
package uart_responder_pkg;

    // Register offsets, decoded from bus_addr_i[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    // STATUS bit positions
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_TX_BUSY   = 2;
    localparam int ST_RX_VALID  = 3;
    localparam int ST_RX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_OVF    = 6;

    // Shortest bit period accepted, in clock cycles
    localparam logic [15:0] DIV_MIN = 16'd16;

    // Serial frame phases, shared by TX and RX engines
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    // Raise a requested bit period to the supported minimum
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        logic [15:0] result;
        if (value < DIV_MIN) begin
            result = DIV_MIN;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_responder_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wdata    write request and data; accepted when not full, or when
//                  full but a pop happens in the same cycle
//   pop            read request; ignored when empty
//   head           combinational oldest entry
//   full, empty    status evaluated before the clock edge
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_responder_fifo
    import uart_responder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign do_pop_s  = pop && !empty_s;
    // When full, the slot being written is the one the pop releases
    assign do_push_s = push && (!full_s || do_pop_s);

    assign head  = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_s;
    assign empty = empty_s;

    // Storage array write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read and write pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_responder.sv
// UART responder on the core's load/store bus.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   bus_cs_i             chip select; a cycle with it high is one access
//   bus_addr_i           byte address, [3:2] selects DATA/STATUS/DIV
//   bus_data_i           write data
//   bus_we_i             1 = write, 0 = read
//   bus_hb_i             access size, unused (all accesses are words)
//   uart_data_o          combinational read data for the current address
//   uart_tx_o            8N1 serial output, idle high
//   uart_rx_i            8N1 serial input, asynchronous to clk_i
//   irq_o                registered "receive FIFO not empty"
module uart_responder
    import uart_responder_pkg::*;
#(
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        bus_cs_i,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_data_i,
    input  logic        bus_we_i,
    input  logic [1:0]  bus_hb_i,
    output logic [31:0] uart_data_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);

    // Bus decode
    logic [1:0]  addr_s;
    logic        wr_s;
    logic        rd_s;
    logic        tx_push_s;
    logic        tx_ovf_set_s;
    logic        rx_pop_s;
    logic        status_rd_s;
    logic        unused_bits_s;

    // Registers and flags
    logic [15:0] div_r;
    logic        tx_ovf_r;
    logic        rx_ovf_r;
    logic        frame_err_r;
    logic        irq_r;
    logic [31:0] status_s;
    logic [31:0] rdata_s;

    // FIFO interfaces
    logic [7:0]  tx_head_s;
    logic        tx_full_s;
    logic        tx_empty_s;
    logic        tx_pop_s;
    logic [7:0]  rx_head_s;
    logic        rx_full_s;
    logic        rx_empty_s;
    logic        rx_push_s;
    logic        rx_ovf_set_s;
    logic        rx_ferr_s;

    // TX engine
    uart_state_e tx_state_r, tx_state_n_s;
    logic [15:0] tx_cnt_r, tx_cnt_n_s;
    logic [2:0]  tx_bit_r, tx_bit_n_s;
    logic [7:0]  tx_shift_r, tx_shift_n_s;
    logic        tx_line_r, tx_line_n_s;

    // RX engine
    logic        rx_meta_r;
    logic        rx_sync_r;
    uart_state_e rx_state_r, rx_state_n_s;
    logic [15:0] rx_cnt_r, rx_cnt_n_s;
    logic [2:0]  rx_bit_r, rx_bit_n_s;
    logic [7:0]  rx_shift_r, rx_shift_n_s;
    logic [15:0] rx_half_s;

    assign addr_s       = bus_addr_i[3:2];
    assign wr_s         = bus_cs_i && bus_we_i;
    assign rd_s         = bus_cs_i && !bus_we_i;
    assign tx_push_s    = wr_s && (addr_s == REG_DATA) && !tx_full_s;
    assign tx_ovf_set_s = wr_s && (addr_s == REG_DATA) && tx_full_s;
    assign rx_pop_s     = rd_s && (addr_s == REG_DATA) && !rx_empty_s;
    assign status_rd_s  = rd_s && (addr_s == REG_STATUS);
    // A DATA read in the same cycle frees a slot, so that push is not an overrun
    assign rx_ovf_set_s = rx_push_s && rx_full_s && !rx_pop_s;
    assign rx_half_s    = {1'b0, div_r[15:1]} - 16'd1;
    assign unused_bits_s = ^{bus_addr_i[31:4], bus_addr_i[1:0],
                             bus_data_i[31:16], bus_hb_i};

    uart_responder_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (tx_push_s),
        .wdata (bus_data_i[7:0]),
        .pop   (tx_pop_s),
        .head  (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s)
    );

    uart_responder_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (rx_push_s),
        .wdata (rx_shift_r),
        .pop   (rx_pop_s),
        .head  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s)
    );

    // STATUS word assembly
    always_comb begin
        status_s               = 32'h0;
        status_s[ST_TX_FULL]   = tx_full_s;
        status_s[ST_TX_EMPTY]  = tx_empty_s;
        status_s[ST_TX_BUSY]   = (tx_state_r != S_IDLE);
        status_s[ST_RX_VALID]  = !rx_empty_s;
        status_s[ST_RX_OVF]    = rx_ovf_r;
        status_s[ST_FRAME_ERR] = frame_err_r;
        status_s[ST_TX_OVF]    = tx_ovf_r;
    end

    // Zero-wait read data mux
    always_comb begin
        rdata_s = 32'h0;
        case (addr_s)
            REG_DATA: begin
                if (rx_empty_s) begin
                    rdata_s = 32'h0;
                end else begin
                    rdata_s = {24'h0, rx_head_s};
                end
            end
            REG_STATUS: rdata_s = status_s;
            REG_DIV:    rdata_s = {16'h0, div_r};
            default:    rdata_s = 32'h0;
        endcase
    end

    assign uart_data_o = rdata_s;
    assign uart_tx_o   = tx_line_r;
    assign irq_o       = irq_r;

    // Bit period register; values below the minimum are raised
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_r <= DIV_RESET;
        end else if (wr_s && (addr_s == REG_DIV)) begin
            div_r <= clamp_div(bus_data_i[15:0]);
        end else begin
            div_r <= div_r;
        end
    end

    // Sticky error flags; a new event wins over a STATUS read clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_ovf_r    <= 1'b0;
            rx_ovf_r    <= 1'b0;
            frame_err_r <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            tx_ovf_r    <= tx_ovf_set_s || (tx_ovf_r && !status_rd_s);
            rx_ovf_r    <= rx_ovf_set_s || (rx_ovf_r && !status_rd_s);
            frame_err_r <= rx_ferr_s || (frame_err_r && !status_rd_s);
            irq_r       <= !rx_empty_s;
        end
    end

    // TX next-state logic; the bit period is re-read at every bit boundary
    always_comb begin
        tx_state_n_s = tx_state_r;
        tx_cnt_n_s   = tx_cnt_r;
        tx_bit_n_s   = tx_bit_r;
        tx_shift_n_s = tx_shift_r;
        tx_line_n_s  = tx_line_r;
        tx_pop_s     = 1'b0;
        case (tx_state_r)
            S_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s     = 1'b1;
                    tx_state_n_s = S_START;
                    tx_cnt_n_s   = div_r - 16'd1;
                    tx_shift_n_s = tx_head_s;
                    tx_line_n_s  = 1'b0;
                end else begin
                    tx_line_n_s  = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_state_n_s = S_DATA;
                    tx_cnt_n_s   = div_r - 16'd1;
                    tx_bit_n_s   = 3'd0;
                    tx_line_n_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_n_s   = tx_cnt_r - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_n_s = div_r - 16'd1;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n_s = S_STOP;
                        tx_line_n_s  = 1'b1;
                    end else begin
                        tx_bit_n_s   = tx_bit_r + 3'd1;
                        tx_shift_n_s = {1'b0, tx_shift_r[7:1]};
                        tx_line_n_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_n_s = tx_cnt_r - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_r == 16'd0) begin
                    // Chain straight into the next start bit when more data waits
                    if (!tx_empty_s) begin
                        tx_pop_s     = 1'b1;
                        tx_state_n_s = S_START;
                        tx_cnt_n_s   = div_r - 16'd1;
                        tx_shift_n_s = tx_head_s;
                        tx_line_n_s  = 1'b0;
                    end else begin
                        tx_state_n_s = S_IDLE;
                        tx_line_n_s  = 1'b1;
                    end
                end else begin
                    tx_cnt_n_s = tx_cnt_r - 16'd1;
                end
            end
            default: begin
                tx_state_n_s = S_IDLE;
                tx_line_n_s  = 1'b1;
            end
        endcase
    end

    // TX state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_r <= S_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h0;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n_s;
            tx_cnt_r   <= tx_cnt_n_s;
            tx_bit_r   <= tx_bit_n_s;
            tx_shift_r <= tx_shift_n_s;
            tx_line_r  <= tx_line_n_s;
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX next-state logic; start is checked mid-bit, then one sample per period
    always_comb begin
        rx_state_n_s = rx_state_r;
        rx_cnt_n_s   = rx_cnt_r;
        rx_bit_n_s   = rx_bit_r;
        rx_shift_n_s = rx_shift_r;
        rx_push_s    = 1'b0;
        rx_ferr_s    = 1'b0;
        case (rx_state_r)
            S_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_n_s = S_START;
                    rx_cnt_n_s   = rx_half_s;
                end else begin
                    rx_cnt_n_s   = rx_cnt_r;
                end
            end
            S_START: begin
                if (rx_cnt_r == 16'd0) begin
                    if (rx_sync_r) begin
                        rx_state_n_s = S_IDLE;
                    end else begin
                        rx_state_n_s = S_DATA;
                        rx_cnt_n_s   = div_r - 16'd1;
                        rx_bit_n_s   = 3'd0;
                    end
                end else begin
                    rx_cnt_n_s = rx_cnt_r - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_shift_n_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_n_s   = div_r - 16'd1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n_s = S_STOP;
                    end else begin
                        rx_bit_n_s   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n_s = rx_cnt_r - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_state_n_s = S_IDLE;
                    if (rx_sync_r) begin
                        rx_push_s = 1'b1;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_cnt_n_s = rx_cnt_r - 16'd1;
                end
            end
            default: begin
                rx_state_n_s = S_IDLE;
            end
        endcase
    end

    // RX state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state_r <= S_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h0;
        end else begin
            rx_state_r <= rx_state_n_s;
            rx_cnt_r   <= rx_cnt_n_s;
            rx_bit_r   <= rx_bit_n_s;
            rx_shift_r <= rx_shift_n_s;
        end
    end

endmodule

// File: doc/uart_responder.md
Name: uart_responder

Overview:
- Bus-side responder for the UART chip-select of the core's load/store bus.
- Decodes core reads and writes to three word registers: DATA, STATUS and DIV.
- Buffers transmit bytes in a FIFO and serialises them as 8N1 on uart_tx_o.
- Deserialises uart_rx_i into a receive FIFO that the core drains through uart_data_o.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 4, RX FIFO entries; power of 2, minimum 2.
- DIV_RESET, 16'd868, bit period in clk_i cycles after reset (100 MHz / 115200).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- bus_cs_i  in  1  UART chip select, one bit of the core's bus_cs vector.
- bus_addr_i  in  32  byte address; only [3:2] decoded.
- bus_data_i  in  32  write data.
- bus_we_i  in  1  write enable.
- bus_hb_i  in  2  access size; ignored, all accesses treated as word.
- uart_data_o  out  32  read data to the core's uart_data_i.
- uart_tx_o  out  1  serial output, idle high.
- uart_rx_i  in  1  serial input, asynchronous.
- irq_o  out  1  high while the RX FIFO is non-empty.

Behaviour:
- Access: a bus access is a cycle with bus_cs_i=1.
  - Write when bus_we_i=1, read otherwise.
  - Side effects take place on the rising clk_i edge that ends the access cycle.
- Read data timing: uart_data_o is combinational from bus_addr_i[3:2] and current state. It is valid in the same cycle (zero-wait read).
- Register map, selected by bus_addr_i[3:2]:
  - 0 DATA, write: pushes bus_data_i[7:0] into the TX FIFO. If the FIFO is full the byte is dropped and tx_ovf is set.
  - 0 DATA, read: returns {24'b0, RX head}, then pops. An empty FIFO reads 0 with no pop.
  - 1 STATUS, read-only: bit0 tx_full, bit1 tx_empty, bit2 tx_busy, bit3 rx_valid, bit4 rx_ovf, bit5 frame_err, bit6 tx_ovf; other bits 0.
  - 1 STATUS: a read clears bits 4..6 at the end of the cycle.
  - 2 DIV, read/write: bits [15:0]. A written value below 16 is stored as 16.
  - 3: reads 0, writes ignored.
- Reset values:
  - uart_tx_o=1, irq_o=0.
  - Both FIFOs empty, sticky flags 0, DIV=DIV_RESET, both FSMs in IDLE.
  - STATUS reads 32'h2.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START, driving uart_tx_o=0.
  - Each state lasts DIV cycles.
  - DATA shifts out 8 bits, LSB first.
  - STOP drives 1 for DIV cycles, then returns to IDLE.
  - Back-to-back bytes have no idle gap.
  - tx_busy=1 whenever the FSM is not in IDLE.
- RX FSM states: IDLE, START, DATA, STOP.
  - uart_rx_i passes through a 2-flop synchroniser, which adds 2 cycles of latency.
  - IDLE: a synchronised 0 starts the frame and moves to START.
  - START: samples at DIV/2. If the sample is 1 it is a glitch, return to IDLE. Otherwise go to DATA.
  - DATA: 8 samples spaced DIV apart, LSB first.
  - STOP: samples once. On 1 the byte is pushed; on 0 the byte is discarded and frame_err is set.
  - The FSM returns to IDLE immediately after the stop sample.
- Push to a full RX FIFO: byte dropped, rx_ovf set.
  - Exception: if a DATA read pops in the same cycle, the push succeeds and no overrun is flagged.
- TX simultaneous push/pop: full/empty are evaluated before the edge.
  - Push to a FIFO that is full at the edge is dropped, even if the FSM pops in that cycle.
  - A push into an empty FIFO is not visible to the FSM until the next cycle.
- DIV changes: a write to DIV takes effect at the next bit boundary. An in-flight bit keeps its old period.
- Mid-frame reset: the asynchronous reset drives uart_tx_o=1 and clears everything immediately. The partial frame is lost.
- FIFO pointers are log2(DEPTH)+1 bits with a wrap bit.
  - full: indices equal, wrap bits differ.
  - empty: pointers equal.
- irq_o is registered rx_valid, lagging the FIFO by at most 1 cycle.

Decomposition:
- Shared header uart_defs.vh holds:
  - register offsets (REG_DATA=0, REG_STATUS=1, REG_DIV=2);
  - STATUS bit positions;
  - TX/RX state encodings;
  - DIV_MIN=16.
- One sub-module, uart_fifo (WIDTH, DEPTH):
  - synchronous push/pop with full/empty flags and a combinational head;
  - instantiated twice, for TX and RX.

Test Plan:
- Reset: release rst_ni, read STATUS -> uart_data_o=32'h2, uart_tx_o=1, irq_o=0. DIV reads 868.
- TX framing: write DIV=16, write DATA=8'hA5.
  - uart_tx_o shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each exactly 16 cycles.
  - STATUS tx_busy=1 during the frame.
- TX overflow: DIV=16, write 10 bytes back-to-back (TX_DEPTH=8).
  - 9 bytes are transmitted: one popped immediately plus 8 buffered.
  - STATUS bit6=1 on the first read, 0 on the second.
- RX receive: DIV=16, drive frame 8'h3C on uart_rx_i.
  - irq_o rises, STATUS bit3=1.
  - DATA read returns 32'h3C, irq_o falls, a second DATA read returns 0.
- RX errors:
  - A frame with stop bit 0 -> FIFO unchanged, frame_err=1.
  - 5 frames without reads (RX_DEPTH=4) -> rx_ovf=1, and the four reads return the first four bytes.
  - A 4-cycle low glitch -> nothing received.
- Mid-frame reset: assert rst_ni low during TX bit 3 of 8'hFF -> uart_tx_o=1 in the same cycle. After release, STATUS=32'h2 and DIV=868.
